lcd8080_apb_bridge: RTL and testbench
=====================================

// Module: lcd8080_apb_bridge
// PURPOSE
//  APB slave driving an 8080-style parallel LCD controller bus (CS/RS/WR/RD, tri-stated data).
//  Parametrised data width, write FIFO for posted command/data writes, and run-time programmable
//  setup/strobe/hold timing. Sits between the CPU APB fabric and the LCD panel pins.
// PARAMETERS
//  DATA_W      16  LCD data bus width (8..32); prdata/pwdata use bits [DATA_W-1:0], rest zero
//  FIFO_DEPTH  4   posted-write FIFO entries (power of 2, >=2); entry = {rs, data[DATA_W-1:0]}
//  CNT_W       8   width of each timing field/counter
//  RST_SETUP   5   reset value of SETUP cycles (RS/CS valid before strobe)
//  RST_WR      10  reset value of WR strobe-low cycles
//  RST_RD      100 reset value of RD strobe-low cycles
//  RST_HOLD    10  reset value of HOLD cycles (strobe high, CS low) after each access
// PORTS
//  clk          in   1       bus and LCD clock
//  nrst         in   1       asynchronous active-low reset; also drives LCD_nrst directly
//  APB_paddr    in   32      byte address; bits [3:2] decoded, others ignored except range check
//  APB_psel     in   1       APB select
//  APB_penable  in   1       APB access phase
//  APB_pwrite   in   1       1=write
//  APB_pwdata   in   32      write data
//  APB_pready   out  1       transfer complete
//  APB_prdata   out  32      read data
//  APB_pslverr  out  1       error on paddr[31:4]!=0, asserted with pready
//  LCD_nrst     out  1       = nrst
//  LCD_csel     out  1       chip select, active low
//  LCD_rs       out  1       0=command, 1=data
//  LCD_wr       out  1       write strobe, active low
//  LCD_rd       out  1       read strobe, active low
//  LCD_data_in  in   DATA_W  panel read data
//  LCD_data_out out  DATA_W  panel write data
//  LCD_data_z   out  DATA_W  per-bit tristate enable, 1=high-Z
// BEHAVIOUR
//  Reset: csel=1 wr=1 rd=1 rs=0 data_out=0 data_z=all-1 prdata=0 pready=0 pslverr=0; FIFO
//   flushed; timing regs = RST_*. Reset mid-access aborts it immediately, nothing retried.
//  Map: 0x0 CMD (rs=0), 0x4 DATA (rs=1), 0x8 TIMING {HOLD,RD,WR,SETUP} 8b each (R/W),
//   0xC STATUS RO {busy[31], fifo_level[7:0]}. Writes to 0xC ignored, pready normal.
//  APB: one access per psel&penable; pready is a 1-cycle pulse; slave idles until penable drops.
//   CMD/DATA write: pushed to FIFO; pready the cycle after penable if FIFO not full, else held
//   low until an entry frees (push and pop same cycle allowed, level unchanged).
//   CMD/DATA read: waits until FIFO empty and LCD FSM idle, then runs one read access; prdata =
//   zero-extended LCD_data_in sampled on last RD-low cycle; pready the next cycle.
//   TIMING/STATUS/error accesses: pready the cycle after penable, no LCD activity.
//  LCD FSM: IDLE -> SETUP -> STROBE -> HOLD -> IDLE.
//   IDLE: pending read (priority only when FIFO empty) or FIFO non-empty starts access; timing
//    fields latched here, so TIMING writes affect only later accesses.
//   SETUP: csel=0, rs driven; for writes data_out=entry, data_z=0; SETUP cycles.
//   STROBE: wr=0 (write) or rd=0 (read) for WR/RD cycles; FIFO popped on STROBE entry.
//   HOLD: strobes=1, csel=0, data still driven for HOLD cycles, then csel=1, data_z=all-1.
//   Back-to-back FIFO entries: HOLD -> SETUP directly, csel stays 0.
//  Counts: field value N gives N cycles; N=0 treated as 1. Counter saturates, never wraps.
//  busy = FSM not IDLE or FIFO non-empty.
// TESTING
//  Reset, write 0x4=0xBEEF -> pready 1 cycle after penable; csel low 1+5+10+10 cycles total,
//   wr low exactly 10 cycles, rs=1, data_out=0xBEEF while driven.
//  Post FIFO_DEPTH+1 writes back-to-back -> first 4 immediate pready, 5th stalls until first
//   pop; panel sees all 5 in order, csel not deasserted between them.
//  Write 0x0=0x0011 then read 0x4 with LCD_data_in=0x1234 -> cmd (rs=0) completes first, then
//   rd low 100 cycles, prdata=0x00001234.
//  Write TIMING=0x00020301 -> next write: setup 1, wr low 3, hold 0->1 cycle; STATUS reads
//   busy=0 level=0 when done.
//  Read 0x20 -> pready with pslverr=1, prdata unchanged, no LCD strobe.
//  Assert nrst during STROBE -> same cycle wr=1, csel=1, data_z=all-1; STATUS level=0 after.

Source files
------------

// File: rtl/lcd8080_apb_bridge.sv
// APB slave driving an 8080-style parallel LCD bus. Writes are posted through a FIFO;
// reads stall the APB access until the panel read cycle has completed.
module lcd8080_apb_bridge #(
    parameter int unsigned DATA_W     = 16,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned CNT_W      = 8,
    parameter int unsigned RST_SETUP  = 5,
    parameter int unsigned RST_WR     = 10,
    parameter int unsigned RST_RD     = 100,
    parameter int unsigned RST_HOLD   = 10
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic [31:0]       APB_paddr,
    input  logic              APB_psel,
    input  logic              APB_penable,
    input  logic              APB_pwrite,
    input  logic [31:0]       APB_pwdata,
    output logic              APB_pready,
    output logic [31:0]       APB_prdata,
    output logic              APB_pslverr,
    output logic              LCD_nrst,
    output logic              LCD_csel,
    output logic              LCD_rs,
    output logic              LCD_wr,
    output logic              LCD_rd,
    input  logic [DATA_W-1:0] LCD_data_in,
    output logic [DATA_W-1:0] LCD_data_out,
    output logic [DATA_W-1:0] LCD_data_z
);
    localparam int unsigned      PtrW     = $clog2(FIFO_DEPTH);
    localparam logic [PtrW:0]    FifoFull = (PtrW + 1)'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] CntOne   = CNT_W'(1);

    typedef enum logic [1:0] {StIdle, StSetup, StStrobe, StHold} state_e;

    state_e            state_q;
    logic [DATA_W:0]   fifo_mem [FIFO_DEPTH];
    logic [PtrW-1:0]   wptr_q, rptr_q;
    logic [PtrW:0]     level_q;
    logic [CNT_W-1:0]  t_setup_q, t_wr_q, t_rd_q, t_hold_q;
    logic [CNT_W-1:0]  lim_setup_q, lim_strobe_q, lim_hold_q, cnt_q;
    logic              is_rd_q, pready_q, pslverr_q, done_q;
    logic [31:0]       prdata_q;
    logic              csel_q, rs_q, wr_q, rd_q;
    logic [DATA_W-1:0] data_out_q, data_z_q;

    logic              apb_act, addr_err, lcd_acc, reg_acc, rd_req, fifo_empty, push, pop;
    logic              phase_done, start_wr, start_rd, busy;
    logic [CNT_W-1:0]  lim_cur;
    logic [DATA_W:0]   head;
    logic [31:0]       timing_rd, status_rd;
    logic              unused_addr;

    // A programmed count of zero still yields one cycle.
    function automatic logic [CNT_W-1:0] eff(input logic [CNT_W-1:0] n);
        return (n == '0) ? CntOne : n;
    endfunction

    always_comb begin
        apb_act    = APB_psel && APB_penable && !pready_q && !done_q;
        addr_err   = |APB_paddr[31:4];
        lcd_acc    = apb_act && !addr_err && !APB_paddr[3];
        reg_acc    = apb_act && (addr_err || APB_paddr[3]);
        rd_req     = lcd_acc && !APB_pwrite;
        fifo_empty = (level_q == '0);
        head       = fifo_mem[rptr_q];
        case (state_q)
            StSetup:  lim_cur = lim_setup_q;
            StStrobe: lim_cur = lim_strobe_q;
            default:  lim_cur = lim_hold_q;
        endcase
        phase_done = (cnt_q >= lim_cur);
        pop        = (state_q == StSetup) && !is_rd_q && phase_done;
        // A full FIFO still accepts a push in the cycle an entry leaves.
        push       = lcd_acc && APB_pwrite && ((level_q != FifoFull) || pop);
        start_wr   = !fifo_empty &&
                     ((state_q == StIdle) || ((state_q == StHold) && phase_done));
        start_rd   = (state_q == StIdle) && fifo_empty && rd_req;
        busy       = (state_q != StIdle) || !fifo_empty;
        timing_rd  = {8'(t_hold_q), 8'(t_rd_q), 8'(t_wr_q), 8'(t_setup_q)};
        status_rd  = 32'(level_q);
        status_rd[31] = busy;
    end

    assign unused_addr = ^APB_paddr[1:0];

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wptr_q] <= {APB_paddr[2], APB_pwdata[DATA_W-1:0]};
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q      <= StIdle;
            wptr_q       <= '0;
            rptr_q       <= '0;
            level_q      <= '0;
            t_setup_q    <= CNT_W'(RST_SETUP);
            t_wr_q       <= CNT_W'(RST_WR);
            t_rd_q       <= CNT_W'(RST_RD);
            t_hold_q     <= CNT_W'(RST_HOLD);
            lim_setup_q  <= CntOne;
            lim_strobe_q <= CntOne;
            lim_hold_q   <= CntOne;
            cnt_q        <= CntOne;
            is_rd_q      <= 1'b0;
            pready_q     <= 1'b0;
            pslverr_q    <= 1'b0;
            done_q       <= 1'b0;
            prdata_q     <= '0;
            csel_q       <= 1'b1;
            rs_q         <= 1'b0;
            wr_q         <= 1'b1;
            rd_q         <= 1'b1;
            data_out_q   <= '0;
            data_z_q     <= '1;
        end else begin
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
            if (!APB_penable) begin
                done_q <= 1'b0;
            end else if (pready_q) begin
                done_q <= 1'b1;
            end

            if (reg_acc) begin
                pready_q  <= 1'b1;
                pslverr_q <= addr_err;
                if (!addr_err && !APB_pwrite) begin
                    prdata_q <= APB_paddr[2] ? status_rd : timing_rd;
                end else if (!addr_err && !APB_paddr[2]) begin
                    t_setup_q <= CNT_W'(APB_pwdata[7:0]);
                    t_wr_q    <= CNT_W'(APB_pwdata[15:8]);
                    t_rd_q    <= CNT_W'(APB_pwdata[23:16]);
                    t_hold_q  <= CNT_W'(APB_pwdata[31:24]);
                end
            end

            if (push) begin
                wptr_q   <= wptr_q + 1'b1;
                pready_q <= 1'b1;
            end
            if (pop) rptr_q <= rptr_q + 1'b1;
            if (push && !pop) begin
                level_q <= level_q + 1'b1;
            end else if (pop && !push) begin
                level_q <= level_q - 1'b1;
            end

            case (state_q)
                StIdle: begin
                    csel_q   <= 1'b1;
                    data_z_q <= '1;
                end
                StSetup: begin
                    if (phase_done) begin
                        state_q <= StStrobe;
                        cnt_q   <= CntOne;
                        if (is_rd_q) rd_q <= 1'b0;
                        else         wr_q <= 1'b0;
                    end else if (cnt_q != '1) begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                StStrobe: begin
                    if (phase_done) begin
                        state_q <= StHold;
                        cnt_q   <= CntOne;
                        wr_q    <= 1'b1;
                        rd_q    <= 1'b1;
                        if (is_rd_q) begin
                            prdata_q <= 32'(LCD_data_in);
                            pready_q <= 1'b1;
                        end
                    end else if (cnt_q != '1) begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: begin
                    if (phase_done) begin
                        state_q <= StIdle;
                        cnt_q   <= CntOne;
                    end else if (cnt_q != '1) begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
            endcase

            // Timing fields are captured per access so TIMING writes never disturb one in flight.
            if (start_wr || start_rd) begin
                state_q      <= StSetup;
                cnt_q        <= CntOne;
                csel_q       <= 1'b0;
                is_rd_q      <= start_rd;
                lim_setup_q  <= eff(t_setup_q);
                lim_strobe_q <= eff(start_rd ? t_rd_q : t_wr_q);
                lim_hold_q   <= eff(t_hold_q);
                if (start_wr) begin
                    rs_q       <= head[DATA_W];
                    data_out_q <= head[DATA_W-1:0];
                    data_z_q   <= '0;
                end else begin
                    rs_q <= APB_paddr[2];
                end
            end
        end
    end

    assign APB_pready   = pready_q;
    assign APB_prdata   = prdata_q;
    assign APB_pslverr  = pslverr_q;
    assign LCD_nrst     = nrst;
    assign LCD_csel     = csel_q;
    assign LCD_rs       = rs_q;
    assign LCD_wr       = wr_q;
    assign LCD_rd       = rd_q;
    assign LCD_data_out = data_out_q;
    assign LCD_data_z   = data_z_q;

endmodule

// File: tb/tb_lcd8080_apb_bridge.sv
// Scoreboard bench for lcd8080_apb_bridge: stimulus pushes expected APB responses and
// panel accesses; negedge monitors pop and compare as the DUT produces them.
module tb_lcd8080_apb_bridge;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          nrst;
    logic [31:0]   paddr, pwdata, prdata;
    logic          psel, penable, pwrite, pready, pslverr;
    logic          lcd_nrst, csel, rs, wr, rd;
    logic [DW-1:0] data_in, data_out, data_z;

    lcd8080_apb_bridge dut (
        .clk          (clk),
        .nrst         (nrst),
        .APB_paddr    (paddr),
        .APB_psel     (psel),
        .APB_penable  (penable),
        .APB_pwrite   (pwrite),
        .APB_pwdata   (pwdata),
        .APB_pready   (pready),
        .APB_prdata   (prdata),
        .APB_pslverr  (pslverr),
        .LCD_nrst     (lcd_nrst),
        .LCD_csel     (csel),
        .LCD_rs       (rs),
        .LCD_wr       (wr),
        .LCD_rd       (rd),
        .LCD_data_in  (data_in),
        .LCD_data_out (data_out),
        .LCD_data_z   (data_z)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        chk_data;
        logic [31:0] data;
        logic        err;
        int          min_lat;
        int          max_lat;
    } apb_exp_t;

    typedef struct {
        logic          is_rd;
        logic          rs;
        logic [DW-1:0] data;
        int            len;
    } lcd_exp_t;

    apb_exp_t apb_q[$];
    lcd_exp_t lcd_q[$];
    int       csel_q[$];
    int       total = 0;
    int       bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // APB monitor: latency counts access-phase cycles with pready still low.
    int       lat = 0;
    apb_exp_t ae;
    always @(negedge clk) begin
        if (!nrst) begin
            lat = 0;
        end else begin
            if (psel && penable && !pready) lat++;
            if (pready) begin
                if (apb_q.size() == 0) begin
                    check("apb_unexpected_pready", 32'd1, 32'd0);
                end else begin
                    ae = apb_q.pop_front();
                    check({ae.name, "_pslverr"}, 32'(pslverr), 32'(ae.err));
                    if (ae.chk_data) check({ae.name, "_prdata"}, prdata, ae.data);
                    check($sformatf("%s_latency_in_range(lat=%0d)", ae.name, lat),
                          32'(lat >= ae.min_lat && lat <= ae.max_lat), 32'd1);
                end
                lat = 0;
            end
        end
    end

    // Panel monitor: one scoreboard entry per strobe pulse, one per csel-low run.
    int            slen = 0;
    int            clen = 0;
    logic          s_rd, s_rs, s_ok;
    logic [DW-1:0] s_data;
    lcd_exp_t      le;
    always @(negedge clk) begin
        if (!nrst) begin
            slen = 0;
            clen = 0;
        end else begin
            if (!wr || !rd) begin
                if (slen == 0) begin
                    s_rd   = !rd;
                    s_rs   = rs;
                    s_data = data_out;
                    s_ok   = 1'b1;
                end
                if (rs !== s_rs || csel !== 1'b0) s_ok = 1'b0;
                if (!wr && (data_out !== s_data || data_z !== '0)) s_ok = 1'b0;
                slen++;
            end else if (slen > 0) begin
                if (lcd_q.size() == 0) begin
                    check("lcd_unexpected_strobe", 32'(slen), 32'd0);
                end else begin
                    le = lcd_q.pop_front();
                    check("lcd_is_read", 32'(s_rd), 32'(le.is_rd));
                    check("lcd_rs", 32'(s_rs), 32'(le.rs));
                    check("lcd_strobe_len", 32'(slen), 32'(le.len));
                    check("lcd_stable_during_strobe", 32'(s_ok), 32'd1);
                    if (!le.is_rd) check("lcd_data_out", 32'(s_data), 32'(le.data));
                end
                slen = 0;
            end
            if (!csel) begin
                clen++;
            end else if (clen > 0) begin
                if (csel_q.size() == 0) check("csel_unexpected", 32'(clen), 32'd0);
                else                    check("csel_low_len", 32'(clen), 32'(csel_q.pop_front()));
                clen = 0;
            end
        end
    end

    task automatic apb(input string name, input logic w, input logic [31:0] a,
                       input logic [31:0] wd, input logic chk, input logic [31:0] exp_d,
                       input logic err, input int min_lat, input int max_lat);
        int n;
        apb_q.push_back('{name, chk, exp_d, err, min_lat, max_lat});
        @(posedge clk);
        #1;
        psel    = 1'b1;
        penable = 1'b0;
        pwrite  = w;
        paddr   = a;
        pwdata  = wd;
        @(posedge clk);
        #1;
        penable = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!pready && n < 3000);
        if (!pready) begin
            total++;
            bad++;
            $display("FAIL %s_timeout: got no pready want pready", name);
        end
        @(posedge clk);
        #1;
        psel    = 1'b0;
        penable = 1'b0;
    endtask

    task automatic exp_lcd(input logic is_rd, input logic r, input logic [DW-1:0] d,
                           input int len);
        lcd_q.push_back('{is_rd, r, d, len});
    endtask

    task automatic drain(input string name);
        int n = 0;
        while ((apb_q.size() != 0 || lcd_q.size() != 0 || csel_q.size() != 0) && n < 5000) begin
            @(negedge clk);
            n++;
        end
        check({name, "_drained"}, 32'(n < 5000), 32'd1);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        int n;
        nrst    = 1'b1;
        psel    = 1'b0;
        penable = 1'b0;
        pwrite  = 1'b0;
        paddr   = '0;
        pwdata  = '0;
        data_in = 16'h1234;
        #1 nrst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_lcd_nrst", 32'(lcd_nrst), 32'd0);
        check("rst_csel", 32'(csel), 32'd1);
        check("rst_wr", 32'(wr), 32'd1);
        check("rst_rd", 32'(rd), 32'd1);
        check("rst_rs", 32'(rs), 32'd0);
        check("rst_data_out", 32'(data_out), 32'h0);
        check("rst_data_z", 32'(data_z), 32'hFFFF);
        check("rst_prdata", prdata, 32'h0);
        check("rst_pready", 32'(pready), 32'd0);
        check("rst_pslverr", 32'(pslverr), 32'd0);
        @(posedge clk);
        #1 nrst = 1'b1;

        apb("timing_rst_rd", 1'b0, 32'h8, 32'h0, 1'b1, 32'h0A640A05, 1'b0, 1, 1);

        // Single data write: csel low for idle-exit + 5 setup + 10 strobe + 10 hold.
        exp_lcd(1'b0, 1'b1, 16'hBEEF, 10);
        csel_q.push_back(26);
        apb("wr_data_beef", 1'b1, 32'h4, 32'h0000BEEF, 1'b0, 32'h0, 1'b0, 1, 1);
        drain("single_write");

        // Longer setup so the 4-deep FIFO fills before its first pop.
        apb("timing_slow_setup", 1'b1, 32'h8, 32'h0A640A14, 1'b0, 32'h0, 1'b0, 1, 1);
        for (int i = 0; i < 5; i++) exp_lcd(1'b0, i[0], 16'hA000 + 16'(i), 10);
        csel_q.push_back(5 * 40 + 1);
        for (int i = 0; i < 4; i++)
            apb($sformatf("burst_wr%0d", i), 1'b1, {29'h0, i[0], 2'b00}, 32'hA000 + i,
                1'b0, 32'h0, 1'b0, 1, 1);
        apb("burst_wr4_stall", 1'b1, 32'h0, 32'hA004, 1'b0, 32'h0, 1'b0, 2, 100);
        drain("burst");
        apb("timing_restore", 1'b1, 32'h8, 32'h0A640A05, 1'b0, 32'h0, 1'b0, 1, 1);

        // Command write then data read: the read waits for the command to finish.
        exp_lcd(1'b0, 1'b0, 16'h0011, 10);
        exp_lcd(1'b1, 1'b1, 16'h0, 100);
        csel_q.push_back(25 + 1 + 115 + 1);
        apb("wr_cmd_11", 1'b1, 32'h0, 32'h00000011, 1'b0, 32'h0, 1'b0, 1, 1);
        apb("rd_data", 1'b0, 32'h4, 32'h0, 1'b1, 32'h00001234, 1'b0, 2, 3000);
        drain("cmd_then_read");

        apb("rd_bad_addr", 1'b0, 32'h20, 32'h0, 1'b1, 32'h00001234, 1'b1, 1, 1);
        apb("wr_status_ignored", 1'b1, 32'hC, 32'hFFFFFFFF, 1'b0, 32'h0, 1'b0, 1, 1);
        apb("rd_status_idle", 1'b0, 32'hC, 32'h0, 1'b1, 32'h0, 1'b0, 1, 1);

        // Short timing: setup 1, wr 3, hold 0 counts as 1.
        apb("wr_timing_fast", 1'b1, 32'h8, 32'h00020301, 1'b0, 32'h0, 1'b0, 1, 1);
        apb("rd_timing_fast", 1'b0, 32'h8, 32'h0, 1'b1, 32'h00020301, 1'b0, 1, 1);
        exp_lcd(1'b0, 1'b1, 16'h005A, 3);
        csel_q.push_back(1 + 3 + 1 + 1);
        apb("wr_data_5a", 1'b1, 32'h4, 32'h0000005A, 1'b0, 32'h0, 1'b0, 1, 1);
        drain("fast_timing");
        apb("rd_status_after_fast", 1'b0, 32'hC, 32'h0, 1'b1, 32'h0, 1'b0, 1, 1);

        // Reset in the middle of a write strobe aborts it at once.
        apb("wr_abort", 1'b1, 32'h4, 32'h000000AA, 1'b0, 32'h0, 1'b0, 1, 1);
        n = 0;
        while (wr !== 1'b0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("abort_saw_strobe", 32'(wr), 32'd0);
        #2 nrst = 1'b0;
        #1;
        check("abort_wr", 32'(wr), 32'd1);
        check("abort_csel", 32'(csel), 32'd1);
        check("abort_data_z", 32'(data_z), 32'hFFFF);
        repeat (2) @(posedge clk);
        #1 nrst = 1'b1;
        repeat (40) @(negedge clk);
        apb("rd_status_after_abort", 1'b0, 32'hC, 32'h0, 1'b1, 32'h0, 1'b0, 1, 1);
        drain("final");

        check("apb_queue_empty", 32'(apb_q.size()), 32'd0);
        check("lcd_queue_empty", 32'(lcd_q.size()), 32'd0);
        check("csel_queue_empty", 32'(csel_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
